// File: rtl/spi_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : spi_controller                                                  |
// | Function : SPI initiator, one MSB-first full-duplex frame, CPOL/CPHA modes |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module spi_controller #(
    parameter int DATA_WIDTH = 16,
    parameter int DIV_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  ena,
    input  logic [1:0]            mode,
    input  logic [DIV_WIDTH-1:0]  clk_div,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  spi_cs_n,
    output logic                  spi_clk,
    output logic                  spi_mosi,
    input  logic                  spi_miso
);

    localparam int EDGES = 2 * DATA_WIDTH;
    localparam int ECW   = $clog2(EDGES + 1);
    localparam logic [ECW-1:0] LAST_EDGE = ECW'(EDGES);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        XFER  = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t                state;
    logic                  cpha_l;
    logic [DIV_WIDTH-1:0]  div_l;
    logic [DATA_WIDTH-1:0] tx_sh;
    logic [DATA_WIDTH-1:0] rx_sh;
    logic [DIV_WIDTH-1:0]  hcnt;
    logic [ECW-1:0]        edge_cnt;

    logic           half_end;
    logic           sample;
    logic [ECW-1:0] next_edge;

    assign half_end  = (hcnt == div_l);
    // The half-period that ends now began at a sampling edge (odd edges for CPHA=0, even for CPHA=1).
    assign sample    = (edge_cnt != '0) && (edge_cnt[0] == ~cpha_l);
    assign next_edge = edge_cnt + 1'b1;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state    <= IDLE;
            cpha_l   <= 1'b0;
            div_l    <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            hcnt     <= '0;
            edge_cnt <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rx_data  <= '0;
            spi_cs_n <= 1'b1;
            spi_clk  <= 1'b0;
            spi_mosi <= 1'b0;
        end else if (ena) begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    spi_clk  <= mode[1];
                    spi_cs_n <= 1'b1;
                    spi_mosi <= 1'b0;
                    busy     <= 1'b0;
                    hcnt     <= '0;
                    edge_cnt <= '0;
                    if (start) begin
                        state    <= SETUP;
                        cpha_l   <= mode[0];
                        div_l    <= clk_div;
                        tx_sh    <= tx_data;
                        rx_sh    <= '0;
                        busy     <= 1'b1;
                        spi_cs_n <= 1'b0;
                        spi_mosi <= ~mode[0] & tx_data[DATA_WIDTH-1];
                    end
                end
                SETUP, XFER: begin
                    if (half_end) begin
                        hcnt     <= '0;
                        spi_clk  <= ~spi_clk;
                        edge_cnt <= next_edge;
                        if (sample) begin
                            rx_sh <= {rx_sh[DATA_WIDTH-2:0], spi_miso};
                        end
                        if (cpha_l && next_edge[0]) begin
                            spi_mosi <= tx_sh[DATA_WIDTH-1];
                            tx_sh    <= tx_sh << 1;
                        end else if (!cpha_l && !next_edge[0] && (next_edge != LAST_EDGE)) begin
                            spi_mosi <= tx_sh[DATA_WIDTH-2];
                            tx_sh    <= tx_sh << 1;
                        end
                        state <= (next_edge == LAST_EDGE) ? HOLD : XFER;
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (half_end) begin
                        hcnt     <= '0;
                        // CPHA=1 samples on the final edge, so its last bit is only captured here.
                        rx_data  <= cpha_l ? {rx_sh[DATA_WIDTH-2:0], spi_miso} : rx_sh;
                        spi_cs_n <= 1'b1;
                        spi_mosi <= 1'b0;
                        done     <= 1'b1;
                        state    <= GAP;
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                GAP: begin
                    if (half_end) begin
                        hcnt  <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
